range_text_writer: RTL and testbench

- Serialises a stream of binary (lower, upper) 64-bit range pairs into the ASCII range-list text format, e.g. "11-22,95-115\n".
- Writes the text one byte per cycle into the puzzle input memory, starting at address 0.
- It is the writer end of the byte-addressed ROM/RAM interface. The day02 range parser reads that interface.
- Used to generate self-test input images on-chip and to round-trip parser verification.

---
 rtl/range_text_writer.sv | 183 ++++++++++++++++++
 tb/tb_range_text_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/range_text_writer.sv
// Serialises (lower, upper) 64-bit range pairs into "lo-hi,lo-hi\n" ASCII text,
// writing one byte per cycle into a byte-addressed memory starting at address 0.
module range_text_writer #(
  parameter int N_ADDR_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_lower,
  input  logic [63:0]            in_upper,
  input  logic                   in_last,
  output logic                   mem_we,
  output logic [N_ADDR_BITS:0]   mem_addr,
  output logic [7:0]             mem_wdata,
  output logic [N_ADDR_BITS:0]   bytes_written,
  output logic                   overflow,
  output logic                   done
);

  localparam int AW = N_ADDR_BITS + 1;
  localparam logic [AW-1:0] ADDR_MAX = '1;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_LO,
    S_EMIT_LO,
    S_DASH,
    S_CONV_HI,
    S_EMIT_HI,
    S_SEP,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic          armed;       // low for the first cycle after reset so in_ready starts at 0
  logic [63:0]   bin_q;
  logic [79:0]   bcd_q;
  logic [79:0]   bcd_adj;
  logic [63:0]   hi_q;
  logic          last_q;
  logic [5:0]    conv_cnt;
  logic [4:0]    emit_cnt;
  logic [AW-1:0] bytes_q;
  logic          ovf_q;

  logic          accept;
  logic          emitting;
  logic          at_limit;
  logic          conv_done;
  logic          emit_last;
  logic [4:0]    ndig;
  logic [4:0]    dig_sel;
  logic [3:0]    digit;
  logic [7:0]    intended_byte;

  assign accept    = in_valid && in_ready;
  assign emitting  = (state == S_EMIT_LO) || (state == S_DASH) ||
                     (state == S_EMIT_HI) || (state == S_SEP);
  assign at_limit  = (bytes_q == ADDR_MAX);
  assign conv_done = (conv_cnt == 6'd63);
  assign emit_last = (emit_cnt == (ndig - 5'd1));
  assign dig_sel   = ndig - 5'd1 - emit_cnt;
  assign digit     = bcd_q[{dig_sel, 2'b00} +: 4];

  // Double-dabble add-3 step applied to every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 20; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Digit count from the most significant nonzero digit; zero still prints one digit.
  always_comb begin
    ndig = 5'd1;
    for (int i = 0; i < 20; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) ndig = 5'(i + 1);
    end
  end

  // NOTE: sequential state updates use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = S_CONV_LO;
      S_CONV_LO: if (conv_done) state_next = S_EMIT_LO;
      S_EMIT_LO: begin
        if (at_limit)       state_next = S_DONE;
        else if (emit_last) state_next = S_DASH;
      end
      S_DASH:    state_next = at_limit ? S_DONE : S_CONV_HI;
      S_CONV_HI: if (conv_done) state_next = S_EMIT_HI;
      S_EMIT_HI: begin
        if (at_limit)       state_next = S_DONE;
        else if (emit_last) state_next = S_SEP;
      end
      S_SEP:     state_next = (at_limit || last_q) ? S_DONE : S_IDLE;
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    intended_byte = 8'h00;
    case (state)
      S_EMIT_LO, S_EMIT_HI: intended_byte = ASCII_ZERO + {4'h0, digit};
      S_DASH:               intended_byte = ASCII_DASH;
      S_SEP:                intended_byte = last_q ? ASCII_LF : ASCII_COMMA;
      default:              intended_byte = 8'h00;
    endcase

    in_ready      = armed && (state == S_IDLE);
    mem_we        = emitting;
    mem_addr      = bytes_q;
    // The last addressable byte is always forced to a terminator for the parser.
    mem_wdata     = emitting ? (at_limit ? ASCII_LF : intended_byte) : 8'h00;
    bytes_written = bytes_q;
    overflow      = ovf_q;
    done          = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      hi_q     <= '0;
      last_q   <= 1'b0;
      conv_cnt <= '0;
      emit_cnt <= '0;
      bytes_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            bin_q    <= in_lower;
            hi_q     <= in_upper;
            last_q   <= in_last;
            bcd_q    <= '0;
            conv_cnt <= '0;
          end
        end
        S_CONV_LO, S_CONV_HI: begin
          bcd_q    <= (bcd_adj << 1) | {79'd0, bin_q[63]};
          bin_q    <= bin_q << 1;
          conv_cnt <= conv_cnt + 6'd1;
          emit_cnt <= '0;
        end
        S_EMIT_LO, S_EMIT_HI: emit_cnt <= emit_cnt + 5'd1;
        S_DASH: begin
          bin_q    <= hi_q;
          bcd_q    <= '0;
          conv_cnt <= '0;
        end
        default: ;
      endcase

      // The count saturates at the last address; overflow marks the truncation.
      if (emitting) begin
        if (at_limit) ovf_q   <= 1'b1;
        else          bytes_q <= bytes_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_range_text_writer.sv
// Directed self-checking bench for range_text_writer: captures memory writes and
// compares the produced text and status outputs against hand-written expectations.
module tb_range_text_writer;

  localparam logic [63:0] U64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default 17-bit address space.
  logic        rst, in_valid, in_ready, in_last;
  logic [63:0] in_lower, in_upper;
  logic        mem_we, overflow, done;
  logic [16:0] mem_addr, bytes_written;
  logic [7:0]  mem_wdata;

  // Small instance with an 8-byte address space for the overflow case.
  logic        rst_b, in_valid_b, in_ready_b, in_last_b;
  logic [63:0] in_lower_b, in_upper_b;
  logic        mem_we_b, overflow_b, done_b;
  logic [2:0]  mem_addr_b, bytes_written_b;
  logic [7:0]  mem_wdata_b;

  range_text_writer #(.N_ADDR_BITS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lower(in_lower), .in_upper(in_upper), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .bytes_written(bytes_written), .overflow(overflow), .done(done)
  );

  range_text_writer #(.N_ADDR_BITS(2)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_lower(in_lower_b), .in_upper(in_upper_b), .in_last(in_last_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .bytes_written(bytes_written_b), .overflow(overflow_b), .done(done_b)
  );

  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:7];
  int         wr_a;
  logic       mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
      for (int i = 0; i < 8; i++)   mem_b[i] <= 8'h00;
      wr_a <= 0;
    end else begin
      if (mem_we) begin
        mem_a[mem_addr[7:0]] <= mem_wdata;
        wr_a <= wr_a + 1;
      end
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},      64'(in_ready), 64'd0);
    check({tag, "_mem_we"},        64'(mem_we), 64'd0);
    check({tag, "_mem_addr"},      64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"},     64'(mem_wdata), 64'd0);
    check({tag, "_bytes_written"}, 64'(bytes_written), 64'd0);
    check({tag, "_overflow"},      64'(overflow), 64'd0);
    check({tag, "_done"},          64'(done), 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; mem_clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
  endtask

  // Offers one pair, waits (bounded) for the handshake, then drops in_valid.
  task automatic send_pair(input string tag, input logic [63:0] lo, input logic [63:0] hi,
                           input logic last);
    int c;
    @(negedge clk);
    in_valid = 1'b1; in_lower = lo; in_upper = hi; in_last = last;
    c = 0;
    while (!in_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_text(input string tag, input string s);
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(mem_a[i]), 64'(s[i]));
    check({tag, "_write_count"}, 64'(wr_a), 64'(s.len()));
    check({tag, "_bytes_written"}, 64'(bytes_written), 64'(s.len()));
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1; rst_b = 1'b1; mem_clr = 1'b1;
    in_valid = 1'b0; in_lower = '0; in_upper = '0; in_last = 1'b0;
    in_valid_b = 1'b0; in_lower_b = '0; in_upper_b = '0; in_last_b = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Single pair with terminator; ready must stay low after done.
    send_pair("p11_22", 64'd11, 64'd22, 1'b1);
    wait_done("p11_22");
    check_text("p11_22", "11-22\n");
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_done", 64'(in_ready), 64'd0);
    check("no_write_after_done", 64'(mem_we), 64'd0);
    in_valid = 1'b0;

    // Zero lower bound prints a single digit.
    reset_dut();
    send_pair("p0_5", 64'd0, 64'd5, 1'b1);
    wait_done("p0_5");
    check_text("p0_5", "0-5\n");

    // Two back-to-back pairs with in_valid held high throughout.
    reset_dut();
    @(negedge clk);
    in_valid = 1'b1; in_lower = 64'd95; in_upper = 64'd115; in_last = 1'b0;
    c = 0;
    while (!in_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("two_accept1", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_lower = 64'd998; in_upper = 64'd1012; in_last = 1'b1;
    c = 0;
    while (!in_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    // 64 + 2 + 1 + 64 + 3 + 1 busy cycles for (95, 115).
    check("two_busy_cycles", 64'(c), 64'd135);
    check("two_bytes_mid", 64'(bytes_written), 64'd7);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("two");
    check_text("two", "95-115,998-1012\n");

    // Full-width 20-digit values.
    reset_dut();
    send_pair("max", U64_MAX, U64_MAX, 1'b1);
    wait_done("max");
    check_text("max", "18446744073709551615-18446744073709551615\n");

    // Overflow in an 8-byte space: last byte becomes the terminator.
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    in_valid_b = 1'b1; in_lower_b = 64'd123456; in_upper_b = 64'd7; in_last_b = 1'b1;
    c = 0;
    while (!in_ready_b && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("ovf_accept", 64'(in_ready_b), 64'd1);
    @(negedge clk);
    in_valid_b = 1'b0;
    c = 0;
    while (!done_b && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("ovf_done", 64'(done_b), 64'd1);
    check("ovf_flag", 64'(overflow_b), 64'd1);
    check("ovf_ready", 64'(in_ready_b), 64'd0);
    begin
      string s;
      s = "123456-\n";
      for (int i = 0; i < 8; i++)
        check($sformatf("ovf_byte%0d", i), 64'(mem_b[i]), 64'(s[i]));
    end

    // Reset in the middle of emitting the upper bound, then restart cleanly.
    reset_dut();
    send_pair("abort", 64'd95, 64'd115, 1'b0);
    c = 0;
    while (!(mem_we && mem_addr == 17'd3) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("abort_reach_emit_hi", 64'(mem_wdata), 64'h31);
    rst = 1'b1; mem_clr = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(in_ready), 64'd1);
    send_pair("restart", 64'd11, 64'd22, 1'b1);
    wait_done("restart");
    check_text("restart", "11-22\n");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
